wb_regfile_writer: RTL

- Sole writer for the single regfile write port (load/dest/in).
- Merges two result producers:
  - in-order pipeline writeback, which can never stall;
  - a multi-cycle unit (mul/div), whose results are buffered in a small FIFO and drained into idle write slots.
- Holds a pending-register scoreboard so ID can stall RAW/WAW hazards on multi-cycle destinations.
- Sits between the WB stage / multi-cycle unit and id_regfile; scoreboard query ports face ID.

---
 rtl/wb_regfile_writer_pkg.sv | 14 +
 rtl/wb_mc_fifo.sv | 46 ++++
 rtl/wb_regfile_writer.sv | 112 +++++++++++
 3 files changed

// File: rtl/wb_regfile_writer_pkg.sv
// Shared CPU types for the writeback port: register address width and the
// result-bundle layout used by the pipeline and the multi-cycle unit.
package wb_regfile_writer_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/wb_mc_fifo.sv
// Registered synchronous FIFO for multi-cycle results. The head only shows
// entries written on an earlier edge; there is no same-cycle bypass.
module wb_mc_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 37
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so natural pointer overflow is the wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/wb_regfile_writer.sv
// Sole driver of the regfile write port: pipeline writeback has priority,
// buffered multi-cycle results fill idle slots, and a pending scoreboard feeds ID.
module wb_regfile_writer
  import wb_regfile_writer_pkg::*;
#(
  parameter int MC_DEPTH = 2,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_valid,
  input  logic [4:0]        pipe_rd,
  input  logic [DATA_W-1:0] pipe_data,
  input  logic              mc_issue,
  input  logic [4:0]        mc_issue_rd,
  input  logic              mc_done_valid,
  input  logic [4:0]        mc_done_rd,
  input  logic [DATA_W-1:0] mc_done_data,
  output logic              mc_done_ready,
  input  logic [4:0]        q_src_a,
  input  logic [4:0]        q_src_b,
  input  logic [4:0]        q_dest,
  output logic              a_pending,
  output logic              b_pending,
  output logic              d_pending,
  output logic              rf_load,
  output logic [4:0]        rf_dest,
  output logic [DATA_W-1:0] rf_data
);

  localparam int CW = $clog2(MC_DEPTH) + 1;
  localparam int EW = REG_ADDR_W + DATA_W;
  localparam logic [CW-1:0] DEPTH_C = CW'(MC_DEPTH);

  wb_req_t pipe_req;
  wb_req_t mc_req;

  logic [EW-1:0]         head;
  logic [CW-1:0]         count;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [DATA_W-1:0]     head_data;
  logic                  pipe_wr;
  logic                  drain;
  logic                  push;
  logic [31:0]           pending;

  assign pipe_req = '{valid: pipe_valid, rd: pipe_rd, data: XLEN'(pipe_data)};
  assign mc_req   = '{valid: mc_done_valid, rd: mc_done_rd, data: XLEN'(mc_done_data)};

  assign head_rd   = head[DATA_W +: REG_ADDR_W];
  assign head_data = head[DATA_W-1:0];

  assign pipe_wr = pipe_req.valid && (pipe_req.rd != '0);
  assign drain   = !pipe_wr && (count != '0);

  // Results for x0 are accepted so the unit is not stalled, then discarded.
  assign mc_done_ready = (count < DEPTH_C) || drain;
  assign push          = mc_req.valid && mc_done_ready && (mc_req.rd != '0);

  wb_mc_fifo #(
    .DEPTH (MC_DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({mc_req.rd, DATA_W'(mc_req.data)}),
    .pop       (drain),
    .head      (head),
    .count     (count)
  );

  always_comb begin
    rf_load = 1'b0;
    rf_dest = '0;
    rf_data = '0;
    if (pipe_wr) begin
      rf_load = 1'b1;
      rf_dest = pipe_req.rd;
      rf_data = DATA_W'(pipe_req.data);
    end else if (drain) begin
      rf_load = 1'b1;
      rf_dest = head_rd;
      rf_data = head_data;
    end
  end

  // Set is applied after clear so a fresh issue to the draining register survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      if (drain) pending[head_rd] <= 1'b0;
      if (mc_issue && (mc_issue_rd != '0)) pending[mc_issue_rd] <= 1'b1;
    end
  end

  // The draining register reads as ready because the regfile forwards this write.
  assign a_pending = pending[q_src_a] && (q_src_a != '0) && !(drain && (rf_dest == q_src_a));
  assign b_pending = pending[q_src_b] && (q_src_b != '0) && !(drain && (rf_dest == q_src_b));
  assign d_pending = pending[q_dest]  && (q_dest  != '0) && !(drain && (rf_dest == q_dest));

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    !(push && (count == DEPTH_C) && !drain));

  a_drain_was_pending: assert property (@(posedge clk) disable iff (rst)
    !(drain && !pending[head_rd]));

  a_no_waw_on_pending: assert property (@(posedge clk) disable iff (rst)
    !(pipe_wr && pending[pipe_req.rd]));

endmodule
